sn76489_writer: RTL

SN76489_WRITER -- requirements
Module: sn76489_writer

---
 rtl/sn76489_writer.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/sn76489_writer.sv
// rtl/sn76489_writer.sv - SN76489 PSG byte writer: command FIFO feeding a tick-paced ce_n/we_n/ready bus sequencer.
module sn76489_writer #(
  parameter int WE_TICKS   = 4,
  parameter int GAP_TICKS  = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk_en,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_reg,
  input  logic [9:0] cmd_value,
  output logic [0:7] d,
  output logic       we_n,
  output logic       ce_n,
  input  logic       ready,
  output logic       busy
);

  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int MAXT = (WE_TICKS > GAP_TICKS) ? WE_TICKS : GAP_TICKS;
  localparam int CW   = $clog2(MAXT + 1);
  localparam logic [CW-1:0] WE_LAST  = CW'(WE_TICKS - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'(GAP_TICKS - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_WAIT_RDY, S_GAP
  } state_e;

  // FIFO pointers carry one extra wrap bit to separate full from empty
  logic [12:0]   mem_q [FIFO_DEPTH];
  logic [AW:0]   wr_ptr_q, rd_ptr_q;
  logic          full, empty, push, pop;
  logic [12:0]   head;
  logic [2:0]    head_reg;
  logic [9:0]    head_val;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          pend_q, pend_d;
  logic [0:7]    data_q, data_d;
  logic [0:7]    d_q, d_d;
  logic          we_n_q, we_n_d;
  logic          ce_n_q, ce_n_d;

  assign empty     = (wr_ptr_q == rd_ptr_q);
  assign full      = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign cmd_ready = ~full;
  assign push      = cmd_valid & ~full;
  assign pop       = clk_en & (state_q == S_IDLE) & ~empty;
  assign head      = mem_q[rd_ptr_q[AW-1:0]];
  assign head_reg  = head[12:10];
  assign head_val  = head[9:0];

  assign d    = d_q;
  assign we_n = we_n_q;
  assign ce_n = ce_n_q;
  assign busy = ~((state_q == S_IDLE) & empty);

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= {cmd_reg, cmd_value};
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      pend_q   <= 1'b0;
      data_q   <= '0;
      d_q      <= '0;
      we_n_q   <= 1'b1;
      ce_n_q   <= 1'b1;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      data_q  <= data_d;
      d_q     <= d_d;
      we_n_q  <= we_n_d;
      ce_n_q  <= ce_n_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          cnt_d = '0;
          if (!empty) state_d = S_SETUP;
        end
        S_SETUP: begin
          cnt_d   = '0;
          state_d = S_STROBE;
        end
        S_STROBE: begin
          if (cnt_q == WE_LAST) begin
            cnt_d   = '0;
            state_d = S_WAIT_RDY;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        S_WAIT_RDY: begin
          cnt_d = '0;
          if (ready) state_d = S_GAP;
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_d   = '0;
            state_d = pend_q ? S_SETUP : S_IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: begin
          cnt_d   = '0;
          state_d = S_IDLE;
        end
      endcase
    end
  end

  // Registered bus outputs: each change lands on the tick that makes the state transition
  always_comb begin
    d_d    = d_q;
    we_n_d = we_n_q;
    ce_n_d = ce_n_q;
    pend_d = pend_q;
    data_d = data_q;
    if (clk_en) begin
      case (state_q)
        S_IDLE: begin
          if (!empty) begin
            d_d    = {1'b1, head_reg, head_val[3:0]};
            ce_n_d = 1'b0;
            pend_d = ~head_reg[0] & (head_reg != 3'd6);
            data_d = {2'b00, head_val[9:4]};
          end
        end
        S_SETUP: we_n_d = 1'b0;
        S_WAIT_RDY: begin
          if (ready) begin
            we_n_d = 1'b1;
            ce_n_d = 1'b1;
          end
        end
        S_GAP: begin
          if (cnt_q == GAP_LAST && pend_q) begin
            d_d    = data_q;
            ce_n_d = 1'b0;
            pend_d = 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
